// File: rtl/stage_4_mem_pkg.sv
// -----------------------------------------------------------------------------
// stage_4_mem_pkg
// Shared types for the pipeline memory stage.
//   DEF_XLEN / DEF_REG_IDX_W : default data/address and register-index widths
//   data_t, addr_t, reg_id_t, bool_t : convenience scalar types
//   mem_state_e : request FSM states (IDLE, REQ, WAIT)
// -----------------------------------------------------------------------------
package stage_4_mem_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_REG_IDX_W = 5;

  typedef logic [DEF_XLEN-1:0]      data_t;
  typedef logic [DEF_XLEN-1:0]      addr_t;
  typedef logic [DEF_REG_IDX_W-1:0] reg_id_t;
  typedef logic                     bool_t;

  // Fixed encodings so the state value is stable across tools and waveforms.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT
  } mem_state_e;

endpackage

// File: rtl/stage_4_mem_mem_req_fsm.sv
// -----------------------------------------------------------------------------
// mem_req_fsm
// Sequences one data-memory access over the gnt/rvalid handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem_op       : a load or store is presented (only looked at in IDLE)
//   is_load      : held op type of the access in flight (1 = load)
//   dmem_gnt     : request accepted this cycle
//   dmem_rvalid  : load data valid this cycle
//   load_done    : load data is being returned on this edge
//   dmem_req     : request valid (state == REQ)
//   stall_out    : upstream must hold (state != IDLE)
// -----------------------------------------------------------------------------
module mem_req_fsm
  import stage_4_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_op,
  input  logic is_load,
  input  logic dmem_gnt,
  input  logic dmem_rvalid,
  output logic load_done,
  output logic dmem_req,
  output logic stall_out
);

  mem_state_e state_reg;
  mem_state_e state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (!is_load) begin
            state_next = IDLE;
          end else if (dmem_rvalid) begin
            // Zero-latency memory: grant and data in the same cycle.
            state_next = IDLE;
            load_done  = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_next = IDLE;
          load_done  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the state register only, so both drop the moment rst_n falls.
  assign dmem_req  = (state_reg == REQ);
  assign stall_out = (state_reg != IDLE);

endmodule

// File: rtl/stage_4_mem.sv
// -----------------------------------------------------------------------------
// stage_4_mem
// Pipeline memory stage. Passes ALU results straight to write-back in one
// cycle; loads/stores are captured into hold registers and issued over the
// dmem gnt/rvalid handshake while stall_out freezes upstream.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alu_res, rs2_val, rd_idx   : execute results (address / value, store data, rd)
//   mem_load_enable / mem_store_enable / reg_write_enable : instruction controls
//   stall_out                  : upstream hold request
//   dmem_req/we/addr/wdata     : memory request (word address, bits [1:0] = 0)
//   dmem_gnt/rvalid/rdata      : memory response
//   wb_data_out, wb_rd_idx_out, wb_write_enable_out : registered write-back
// -----------------------------------------------------------------------------
module stage_4_mem
  import stage_4_mem_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int REG_IDX_W = DEF_REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      alu_res,
  input  logic [XLEN-1:0]      rs2_val,
  input  logic [REG_IDX_W-1:0] rd_idx,
  input  logic                 mem_load_enable,
  input  logic                 mem_store_enable,
  input  logic                 reg_write_enable,
  output logic                 stall_out,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [XLEN-1:0]      wb_data_out,
  output logic [REG_IDX_W-1:0] wb_rd_idx_out,
  output logic                 wb_write_enable_out
);

  logic                 mem_op;
  logic                 load_done;

  logic [XLEN-1:0]      hold_addr_reg;
  logic [XLEN-1:0]      hold_wdata_reg;
  logic [REG_IDX_W-1:0] hold_rd_reg;
  logic                 hold_rwe_reg;
  logic                 hold_load_reg;

  logic [XLEN-1:0]      wb_data_reg;
  logic [REG_IDX_W-1:0] wb_rd_reg;
  logic                 wb_we_reg;

  assign mem_op = mem_load_enable || mem_store_enable;

  mem_req_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_op      (mem_op),
    .is_load     (hold_load_reg),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .load_done   (load_done),
    .dmem_req    (dmem_req),
    .stall_out   (stall_out)
  );

  // Hold registers: written only when an access is accepted in IDLE, so the
  // request fields stay constant for the whole REQ phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
      hold_rd_reg    <= '0;
      hold_rwe_reg   <= 1'b0;
      hold_load_reg  <= 1'b0;
    end else if (!stall_out && mem_op) begin
      hold_addr_reg  <= {alu_res[XLEN-1:2], 2'b00};
      hold_wdata_reg <= rs2_val;
      hold_rd_reg    <= rd_idx;
      hold_rwe_reg   <= reg_write_enable;
      // Load wins if both enables are set.
      hold_load_reg  <= mem_load_enable;
    end
  end

  // Write-back: data/rd hold across stalls; the strobe is one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_reg <= '0;
      wb_rd_reg   <= '0;
      wb_we_reg   <= 1'b0;
    end else if (!stall_out) begin
      if (mem_op) begin
        wb_we_reg <= 1'b0;
      end else begin
        wb_data_reg <= alu_res;
        wb_rd_reg   <= rd_idx;
        wb_we_reg   <= reg_write_enable && (rd_idx != '0);
      end
    end else if (load_done) begin
      wb_data_reg <= dmem_rdata;
      wb_rd_reg   <= hold_rd_reg;
      wb_we_reg   <= hold_rwe_reg && (hold_rd_reg != '0);
    end else begin
      wb_we_reg <= 1'b0;
    end
  end

  assign dmem_we             = !hold_load_reg;
  assign dmem_addr           = hold_addr_reg;
  assign dmem_wdata          = hold_wdata_reg;
  assign wb_data_out         = wb_data_reg;
  assign wb_rd_idx_out       = wb_rd_reg;
  assign wb_write_enable_out = wb_we_reg;

endmodule

// File: tb/tb_stage_4_mem.sv
// -----------------------------------------------------------------------------
// tb_stage_4_mem
// Scoreboard bench: the issuer computes expected write-backs and memory
// requests from program-order semantics and queues them; a memory responder
// and a write-back monitor pop and compare independently.
// -----------------------------------------------------------------------------
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_res = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_idx = '0;
  logic        mem_load_enable = 1'b0;
  logic        mem_store_enable = 1'b0;
  logic        reg_write_enable = 1'b0;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_rd_idx_out;
  logic        wb_write_enable_out;

  always #5 clk = ~clk;

  stage_4_mem dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alu_res             (alu_res),
    .rs2_val             (rs2_val),
    .rd_idx              (rd_idx),
    .mem_load_enable     (mem_load_enable),
    .mem_store_enable    (mem_store_enable),
    .reg_write_enable    (reg_write_enable),
    .stall_out           (stall_out),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_gnt            (dmem_gnt),
    .dmem_rvalid         (dmem_rvalid),
    .dmem_rdata          (dmem_rdata),
    .wb_data_out         (wb_data_out),
    .wb_rd_idx_out       (wb_rd_idx_out),
    .wb_write_enable_out (wb_write_enable_out)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  wb_t         exp_wb[$];
  req_t        exp_req[$];
  logic [31:0] ref_mem[int];
  logic [31:0] dev_mem[int];

  int tests = 0;
  int fails = 0;
  int cfg_gd = 0;
  int cfg_rv = 0;
  int op_num = 0;

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Present one instruction and wait until the stage consumes it.
  task automatic issue(input logic ld, input logic st, input logic rwe, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2, input int gd, input int rv);
    int          guard;
    int          widx;
    logic [31:0] aligned;
    logic [31:0] v;
    guard = 0;
    alu_res          = alu;
    rs2_val          = rs2;
    rd_idx           = rd;
    mem_load_enable  = ld;
    mem_store_enable = st;
    reg_write_enable = rwe;
    while (stall_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: stall_out still 1 after %0d cycles, required 0", guard);
    end
    cfg_gd  = gd;
    cfg_rv  = rv;
    aligned = alu & 32'hFFFF_FFFC;
    widx    = int'(alu >> 2);
    if (ld) begin
      v = ref_mem.exists(widx) ? ref_mem[widx] : def_word(aligned);
      if (rwe && rd != 5'd0) exp_wb.push_back('{data: v, rd: rd});
      exp_req.push_back('{we: 1'b0, addr: aligned, wdata: 32'h0});
    end else if (st) begin
      ref_mem[widx] = rs2;
      exp_req.push_back('{we: 1'b1, addr: aligned, wdata: rs2});
    end else if (rwe && rd != 5'd0) begin
      exp_wb.push_back('{data: alu, rd: rd});
    end
    $display("[TB] op %0d: %s alu=%h rs2=%h rd=%0d rwe=%0b gnt_dly=%0d rv_dly=%0d",
             op_num, ld ? "LOAD " : (st ? "STORE" : "ALU  "), alu, rs2, rd, rwe, gd, rv);
    op_num++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_nop();
    mem_load_enable  = 1'b0;
    mem_store_enable = 1'b0;
    reg_write_enable = 1'b0;
  endtask

  // Count stall and request cycles of the access currently in flight.
  task automatic measure(input string name, input int exp_stall, input int exp_reqs);
    int s;
    int r;
    s = 0;
    r = 0;
    while (stall_out && s < 100) begin
      s++;
      if (dmem_req) r++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, s, exp_stall);
    check({name, "_req_cycles"}, r, exp_reqs);
  endtask

  // Memory responder: grants after cfg_gd extra cycles, returns load data
  // cfg_rv cycles after the grant, and injects stray rvalids when idle.
  initial begin : responder
    int          gcnt;
    bit          req_active;
    logic [31:0] first_addr;
    logic        first_we;
    bit          rv_pend;
    int          rv_cnt;
    logic [31:0] rv_data;
    logic [31:0] d;
    req_t        r;
    gcnt = 0;
    req_active = 1'b0;
    rv_pend = 1'b0;
    rv_cnt = 0;
    first_addr = '0;
    first_we = 1'b0;
    rv_data = '0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rv_data;
          rv_pend     = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      if (!rst_n) begin
        req_active = 1'b0;
      end else if (dmem_req) begin
        if (!req_active) begin
          req_active = 1'b1;
          first_addr = dmem_addr;
          first_we   = dmem_we;
          gcnt       = cfg_gd;
        end else begin
          check("req_addr_stable", dmem_addr, first_addr);
          check("req_we_stable", dmem_we, first_we);
        end
        if (gcnt == 0) begin
          dmem_gnt   = 1'b1;
          req_active = 1'b0;
          if (exp_req.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL req_unexpected: got request addr=0x%0h we=%0b, required none", dmem_addr, dmem_we);
          end else begin
            r = exp_req.pop_front();
            check("req_we", dmem_we, r.we);
            check("req_addr", dmem_addr, r.addr);
            if (r.we) begin
              check("req_wdata", dmem_wdata, r.wdata);
              dev_mem[int'(dmem_addr >> 2)] = dmem_wdata;
            end else begin
              d = dev_mem.exists(int'(dmem_addr >> 2)) ? dev_mem[int'(dmem_addr >> 2)] : def_word(dmem_addr);
              if (cfg_rv == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = d;
              end else begin
                rv_pend = 1'b1;
                rv_cnt  = cfg_rv - 1;
                rv_data = d;
              end
            end
          end
        end else begin
          gcnt--;
        end
      end else if (!rv_pend && !dmem_rvalid && $urandom_range(0, 7) == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
      end
    end
  end

  // Write-back monitor: every strobe must match the oldest expectation.
  initial begin : wb_monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_write_enable_out) begin
        if (exp_wb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got strobe rd=%0d data=0x%0h, required no write-back",
                   wb_rd_idx_out, wb_data_out);
        end else begin
          e = exp_wb.pop_front();
          check("wb_data", wb_data_out, e.data);
          check("wb_rd", {27'd0, wb_rd_idx_out}, {27'd0, e.rd});
        end
      end
    end
  end

  initial begin : main
    int          kind;
    logic [31:0] maddr;
    int          guard;

    // Reset state.
    #3;
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_stall", stall_out, 1'b0);
    check("rst_wb_we", wb_write_enable_out, 1'b0);
    check("rst_wb_data", wb_data_out, 32'h0);
    check("rst_wb_rd", {27'd0, wb_rd_idx_out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain ALU write-back.
    issue(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, 0, 0);
    drive_nop();
    check("alu_no_stall", stall_out, 1'b0);
    check("alu_wb_data", wb_data_out, 32'h1234);

    // Write to x0 suppresses the strobe.
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF, 32'h0, 0, 0);
    drive_nop();
    check("x0_wb_we", wb_write_enable_out, 1'b0);

    // Store, immediate grant.
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'h103, 32'hDEAD_BEEF, 0, 0);
    drive_nop();
    measure("store_fast", 1, 1);

    // Store that seeds the load below, one cycle of grant delay.
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'hCAFE_F00D, 1, 0);
    drive_nop();
    measure("store_slow", 2, 2);

    // Load: grant after 2 cycles, data 3 cycles after grant.
    issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h200, 32'h0, 2, 3);
    drive_nop();
    measure("load_slow", 6, 3);

    // Load with grant and data in the same cycle.
    issue(1'b1, 1'b0, 1'b1, 5'd12, 32'h101, 32'h0, 0, 0);
    drive_nop();
    measure("load_fast", 1, 1);

    // Randomized instruction stream, back to back.
    for (int i = 0; i < 250; i++) begin
      kind  = $urandom_range(0, 3);
      maddr = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      issue(kind == 2, kind == 3, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            (kind >= 2) ? maddr : $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drive_nop();
    guard = 0;
    while (stall_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);

    // Reset while a load waits for data; the late rvalid must be ignored.
    issue(1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'h0, 0, 6);
    drive_nop();
    @(negedge clk);
    check("wait_stall", stall_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", dmem_req, 1'b0);
    check("async_rst_stall", stall_out, 1'b0);
    check("async_rst_wb_we", wb_write_enable_out, 1'b0);
    check("async_rst_wb_data", wb_data_out, 32'h0);
    exp_wb.delete();
    exp_req.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("wb_queue_drained", exp_wb.size(), 32'd0);
    check("req_queue_drained", exp_req.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_4_mem.md
Name: stage_4_mem

Overview:
Pipeline memory stage, directly downstream of the execute stage. Consumes the registered execute results (ALU result, resolved rs2, rd index, load/store/write enables), performs data-memory accesses over a grant/rvalid handshake with variable latency, and presents registered write-back data. Asserts a stall to freeze upstream stages while an access is outstanding.

Parameters:
XLEN, 32, data and address width
REG_IDX_W, 5, register index width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_res  in  XLEN  execute result: address for load/store, write-back value otherwise
rs2_val  in  XLEN  store data
rd_idx  in  REG_IDX_W  destination register
mem_load_enable  in  1  instruction is a load
mem_store_enable  in  1  instruction is a store
reg_write_enable  in  1  instruction writes rd
stall_out  out  1  upstream must hold its output registers this cycle
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  word address; bits [1:0] forced to 0
dmem_wdata  out  XLEN  store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid this cycle
dmem_rdata  in  XLEN  load data
wb_data_out  out  XLEN  registered write-back value
wb_rd_idx_out  out  REG_IDX_W  registered destination
wb_write_enable_out  out  1  registered write strobe; also the forwarding-valid flag

Behaviour:
- FSM states IDLE, REQ, WAIT. Reset value IDLE.
- Reset (async, rst_n=0): state=IDLE. wb_data_out=0, wb_rd_idx_out=0, wb_write_enable_out=0. Hold registers cleared. dmem_req=0 and stall_out=0 immediately, not at the next edge.
- stall_out = (state != IDLE). This is combinational from the state only.
- dmem_req = (state == REQ). dmem_addr, dmem_we and dmem_wdata come from hold registers and are stable for the whole time dmem_req is high.
- IDLE, no memory op: single-cycle latency.
  - wb_data_out <= alu_res.
  - wb_rd_idx_out <= rd_idx.
  - wb_write_enable_out <= reg_write_enable && rd_idx != 0.
- IDLE with a load or store:
  - Capture alu_res, rs2_val, rd_idx, reg_write_enable and the op type into hold registers.
  - Go to REQ.
  - wb_write_enable_out <= 0 (bubble).
  - The instruction is consumed at this edge. The next instruction arrives from upstream and is held there by stall_out.
- Load and store both asserted: treated as a load. This combination is illegal and not covered by the bench.
- REQ:
  - While gnt=0: stay in REQ and keep the request asserted.
  - gnt with a store: the store is complete. Go to IDLE, wb_write_enable_out <= 0.
  - gnt with a load and rvalid=0: go to WAIT.
  - gnt with a load and rvalid=1 in the same cycle: complete as in WAIT, go directly to IDLE.
- WAIT:
  - dmem_req=0. Stay in WAIT until rvalid.
  - On rvalid: wb_data_out <= dmem_rdata, wb_rd_idx_out <= held rd, wb_write_enable_out <= held reg_write_enable && held rd != 0. Go to IDLE.
- rvalid outside WAIT (or outside REQ for a load) is ignored.
- wb_* hold their values across stall cycles, except that wb_write_enable_out is 0 on every stall cycle. This means a write-back strobe is never repeated.
- Minimum memory-op occupancy is 2 cycles: capture edge, then REQ with immediate gnt. Stall is asserted for 1 + (gnt wait) + (rvalid wait) cycles.
- Word-only accesses. Address bits [1:0] are dropped with no misalignment trap.

Decomposition:
- Shared package: Data/Addr (XLEN), RegId (REG_IDX_W), Bool, and the MemState enum {IDLE, REQ, WAIT}.
- One natural sub-module, mem_req_fsm: state register, next-state logic, dmem_req/stall_out. The datapath registers stay in stage_4_mem.

Test Plan:
- Non-memory op: alu_res=0x1234, rd=5, rwe=1 -> next edge wb_data_out=0x1234, wb_rd_idx_out=5, wb_write_enable_out=1, stall_out stays 0.
- Write to x0: rd=0, rwe=1, alu_res=0xFFFF -> wb_write_enable_out=0.
- Store with immediate gnt: alu_res=0x103, rs2=0xDEADBEEF -> REQ cycle shows dmem_addr=0x100, dmem_we=1, dmem_wdata=0xDEADBEEF; stall_out high exactly 1 cycle; wb_write_enable_out stays 0.
- Load, gnt delayed 2 cycles, rvalid 3 cycles after gnt, rdata=0xCAFEF00D, rd=7:
  - dmem_req high 3 cycles with a stable address; stall_out high 1+2+3 cycles.
  - Then wb_data_out=0xCAFEF00D, rd=7, write strobe high for 1 cycle.
- Load with gnt and rvalid in the same cycle -> returns to IDLE after 2 cycles total with correct write-back.
- Reset asserted while in WAIT -> dmem_req and stall_out drop asynchronously, wb_* go to 0. A late rvalid after reset release causes no write-back.
